// File: rtl/jk_bank_driver.sv
// Steps an external JK flip-flop bank one count at a time toward a requested value,
// emitting per-bit JK excitation and verifying the bank read-back after every step.
//
// state | meaning
// IDLE  | ready for a target request, bank held (J=K=0)
// DRIVE | excitation on jk_j/jk_k for one edge of the bank
// CHECK | bank held, read-back compared to the expected step value
// ERROR | read-back mismatch or step budget exhausted; waits for err_clr
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_STEPS = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_value,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr,
  output logic [WIDTH-1:0] steps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt_r, exp_r, tgt_sel, nxt;
  logic             accept, launch, done_nx;

  // Excitation is registered one cycle ahead so it is live during DRIVE,
  // and the bank has taken exactly one step by the time CHECK samples q_in.
  assign tgt_sel = (state == IDLE) ? tgt_value : tgt_r;
  assign nxt     = (tgt_sel > q_in) ? q_in + WIDTH'(1) : q_in - WIDTH'(1);
  assign accept  = (state == IDLE) && tgt_valid;
  assign launch  = (state_nx == DRIVE);
  assign done_nx = (accept && (q_in == tgt_value)) ||
                   ((state == CHECK) && (q_in == exp_r) && (q_in == tgt_r));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (tgt_valid && (q_in != tgt_value)) state_nx = DRIVE;
      DRIVE: state_nx = CHECK;
      CHECK: begin
        if (q_in != exp_r)                  state_nx = ERROR;
        else if (q_in == tgt_r)             state_nx = IDLE;
        else if (steps == WIDTH'(MAX_STEPS)) state_nx = ERROR;
        else                                state_nx = DRIVE;
      end
      ERROR: if (err_clr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == IDLE);
    busy      = (state == DRIVE) || (state == CHECK);
    err       = (state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_r <= '0;
      exp_r <= '0;
      jk_j  <= '0;
      jk_k  <= '0;
      steps <= '0;
      done  <= 1'b0;
    end else begin
      done <= done_nx;
      jk_j <= launch ? (~q_in & nxt) : '0;
      jk_k <= launch ? (q_in & ~nxt) : '0;
      if (launch) exp_r <= nxt;
      if (accept) begin
        tgt_r <= tgt_value;
        steps <= '0;
      end else if (state == DRIVE) begin
        steps <= steps + WIDTH'(1);
      end
    end
  end

endmodule
